pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Run/step controller for the MIPS pipeline. Sits between the debug unit (start, mode, step commands) and the pipeline registers, and owns every enable, bubble and flush strobe. It merges the hazard detection unit's bubble request, branch-taken flush and exception requests. On a HALT it drains the pipeline and signals end of program.

## Interface
- CANT_CICLOS_DRENADO, 4, cycles the pipeline keeps advancing after HALT is accepted (≥1)
- CANT_BITS_CONTADOR, 16, width of the executed-cycle counter
- i_clock  in  1  system clock, rising edge
- i_reset  in  1  synchronous, active-low reset
- i_start  in  1  start program, sampled in IDLE/DONE
- i_modo_ejecucion  in  1  0 = continuous, 1 = step; sampled only with i_start
- i_step  in  1  step command; rising edge detected internally
- i_bit_burbuja  in  1  load-use stall request from hazard detection unit
- i_branch_taken  in  1  branch/jump resolved taken in ID
- i_halt_detected  in  1  HALT decoded in ID
- i_exception  in  1  exception raised this cycle
- o_enable_pc  out  1  PC write enable
- o_enable_if_id  out  1  IF/ID register enable
- o_enable_pipeline  out  1  ID/EX, EX/MEM, MEM/WB enables
- o_burbuja_id_ex  out  1  inject NOP into ID/EX
- o_flush_if_id  out  1  clear IF/ID
- o_disable_for_exception  out  1  to hazard detection unit, suppresses bubble during exception
- o_fin_programa  out  1  program finished
- o_contador_ciclos  out  CANT_BITS_CONTADOR  cycles with o_enable_pipeline=1
- o_estado  out  3  current FSM state

## Operation
- States/encoding: IDLE=0, RUN=1, STEP_WAIT=2, STEP_EXEC=3, DRAIN=4, DONE=5. "Active" = RUN or STEP_EXEC.
- Transitions:
  - IDLE/DONE + i_start → RUN if i_modo_ejecucion=0, else STEP_WAIT. Counter clears.
  - RUN + accepted HALT → DRAIN.
  - STEP_WAIT + i_step rising edge → STEP_EXEC.
  - STEP_EXEC → STEP_WAIT. With accepted HALT → DRAIN.
  - DRAIN → DONE after CANT_CICLOS_DRENADO cycles.
  - DONE holds until i_start or reset.
- Active-state outputs, by priority:
  - exception: o_enable_pc=1 (loads vector), o_enable_if_id=1, o_flush_if_id=1, o_burbuja_id_ex=1, o_enable_pipeline=1, o_disable_for_exception=1.
  - else i_bit_burbuja: o_enable_pc=0, o_enable_if_id=0, o_burbuja_id_ex=1, o_enable_pipeline=1, o_flush_if_id=0.
  - else i_branch_taken: o_enable_pc=1, o_enable_if_id=1, o_flush_if_id=1, o_enable_pipeline=1.
  - else HALT: o_enable_pc=0, o_enable_if_id=0, o_enable_pipeline=1; HALT accepted.
  - else: o_enable_pc, o_enable_if_id, o_enable_pipeline = 1; strobes 0.
- HALT is accepted only when no exception and no bubble occur in the same cycle. When HALT coincides with an exception or bubble, the HALT is ignored and is re-evaluated on a later cycle.
- IDLE, STEP_WAIT, DONE: all enables and strobes 0.
- DRAIN: o_enable_pc=0, o_enable_if_id=0, o_enable_pipeline=1, o_burbuja_id_ex=1. i_bit_burbuja, i_branch_taken, i_halt_detected and i_exception are ignored.
- o_fin_programa=1 only in DONE.
- Counter increments every cycle o_enable_pipeline=1 and saturates at all-ones.
- i_step held high yields exactly one STEP_EXEC. A new step requires i_step to be sampled low first. The step edge register resets to 1, so a step held high through reset is not taken.
- i_start while in RUN, STEP_WAIT, STEP_EXEC or DRAIN is ignored.

## Timing
- State, counter, drain counter and step-edge flop are registered. All enable/strobe outputs are combinational from state and current inputs: zero-cycle response to hazards.
- i_start sampled in cycle N → first active cycle is N+1.
- HALT accepted in cycle N → DRAIN occupies N+1 … N+CANT_CICLOS_DRENADO → DONE at N+CANT_CICLOS_DRENADO+1.
- Reset (i_reset=0 at an edge), including mid-run or mid-drain: state IDLE; counter 0; all outputs 0; o_estado=0.

## Test plan
- Reset then start, mode=0, 10 idle cycles → o_estado=1, all three enables =1, o_contador_ciclos=10.
- RUN with i_bit_burbuja=1 for 1 cycle → that cycle o_enable_pc=0, o_enable_if_id=0, o_burbuja_id_ex=1. Add i_branch_taken=1 in the same cycle → o_flush_if_id=0.
- RUN with i_exception=1 and i_bit_burbuja=1 together → o_disable_for_exception=1, o_flush_if_id=1, o_enable_pc=1.
- Mode=1, hold i_step high 5 cycles, then toggle it twice → exactly 3 STEP_EXEC cycles; counter=3.
- i_halt_detected in RUN at cycle N (default parameter) → o_estado=4 for N+1…N+4, then o_fin_programa=1 at N+5 with the counter frozen. i_start in DONE → counter 0 and back to RUN.
- i_reset=0 during DRAIN → next cycle o_estado=0, all outputs 0. i_halt_detected with i_bit_burbuja → no DRAIN entry.

Source files
------------

// File: rtl/pipeline_sequencer_if.sv
// Control bundle between the debug unit / hazard logic and the run/step sequencer.
// The sequencer is the slave; the debug and hazard side is the master.
interface pipeline_sequencer_if #(
    parameter int CANT_BITS_CONTADOR = 16
);
    // Handshake: i_start is a level that is consumed on the first clock where the
    // sequencer sits in IDLE/DONE. i_step is consumed only on its rising edge
    // while waiting for a step. All hazard inputs get a same-cycle answer.
    logic                          i_start;
    logic                          i_modo_ejecucion;
    logic                          i_step;
    logic                          i_bit_burbuja;
    logic                          i_branch_taken;
    logic                          i_halt_detected;
    logic                          i_exception;
    logic                          o_enable_pc;
    logic                          o_enable_if_id;
    logic                          o_enable_pipeline;
    logic                          o_burbuja_id_ex;
    logic                          o_flush_if_id;
    logic                          o_disable_for_exception;
    logic                          o_fin_programa;
    logic [CANT_BITS_CONTADOR-1:0] o_contador_ciclos;
    logic [2:0]                    o_estado;

    modport master (
        output i_start, i_modo_ejecucion, i_step, i_bit_burbuja,
               i_branch_taken, i_halt_detected, i_exception,
        input  o_enable_pc, o_enable_if_id, o_enable_pipeline, o_burbuja_id_ex,
               o_flush_if_id, o_disable_for_exception, o_fin_programa,
               o_contador_ciclos, o_estado
    );

    modport slave (
        input  i_start, i_modo_ejecucion, i_step, i_bit_burbuja,
               i_branch_taken, i_halt_detected, i_exception,
        output o_enable_pc, o_enable_if_id, o_enable_pipeline, o_burbuja_id_ex,
               o_flush_if_id, o_disable_for_exception, o_fin_programa,
               o_contador_ciclos, o_estado
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// Run/step controller for the MIPS pipeline: owns all pipeline enables, bubbles and
// flushes, merges hazard/branch/exception requests, and drains the pipe on HALT.
module pipeline_sequencer #(
    parameter int CANT_CICLOS_DRENADO = 4,
    parameter int CANT_BITS_CONTADOR  = 16
) (
    input logic                 i_clock,
    input logic                 i_reset,
    pipeline_sequencer_if.slave bus
);
    localparam int DW = (CANT_CICLOS_DRENADO > 1) ? $clog2(CANT_CICLOS_DRENADO) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        STEP_WAIT = 3'd2,
        STEP_EXEC = 3'd3,
        DRAIN     = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t                        state;
    logic [CANT_BITS_CONTADOR-1:0] contador;
    logic [DW-1:0]                 drain_cnt;
    logic                          step_q;

    logic en_pc, en_if_id, en_pipe, burbuja, flush, dis_exc, halt_ok;
    logic step_rise;

    assign step_rise = bus.i_step & ~step_q;

    // Priority: exception > load-use bubble > taken branch > HALT.
    always_comb begin
        en_pc    = 1'b0;
        en_if_id = 1'b0;
        en_pipe  = 1'b0;
        burbuja  = 1'b0;
        flush    = 1'b0;
        dis_exc  = 1'b0;
        halt_ok  = 1'b0;
        case (state)
            RUN, STEP_EXEC: begin
                en_pipe = 1'b1;
                if (bus.i_exception) begin
                    en_pc    = 1'b1;
                    en_if_id = 1'b1;
                    flush    = 1'b1;
                    burbuja  = 1'b1;
                    dis_exc  = 1'b1;
                end else if (bus.i_bit_burbuja) begin
                    burbuja = 1'b1;
                end else if (bus.i_branch_taken) begin
                    en_pc    = 1'b1;
                    en_if_id = 1'b1;
                    flush    = 1'b1;
                end else if (bus.i_halt_detected) begin
                    halt_ok = 1'b1;
                end else begin
                    en_pc    = 1'b1;
                    en_if_id = 1'b1;
                end
            end
            DRAIN: begin
                en_pipe = 1'b1;
                burbuja = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state     <= IDLE;
            contador  <= '0;
            drain_cnt <= '0;
            step_q    <= 1'b1;
        end else begin
            step_q <= bus.i_step;
            if (en_pipe && (contador != '1))
                contador <= contador + 1'b1;
            case (state)
                IDLE, DONE: begin
                    if (bus.i_start) begin
                        state    <= bus.i_modo_ejecucion ? STEP_WAIT : RUN;
                        contador <= '0;
                    end
                end
                RUN: begin
                    if (halt_ok) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                STEP_WAIT: begin
                    if (step_rise)
                        state <= STEP_EXEC;
                end
                STEP_EXEC: begin
                    state     <= halt_ok ? DRAIN : STEP_WAIT;
                    drain_cnt <= '0;
                end
                DRAIN: begin
                    if (drain_cnt == DW'(CANT_CICLOS_DRENADO - 1))
                        state <= DONE;
                    else
                        drain_cnt <= drain_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_enable_pc             = en_pc;
    assign bus.o_enable_if_id          = en_if_id;
    assign bus.o_enable_pipeline       = en_pipe;
    assign bus.o_burbuja_id_ex         = burbuja;
    assign bus.o_flush_if_id           = flush;
    assign bus.o_disable_for_exception = dis_exc;
    assign bus.o_fin_programa          = (state == DONE);
    assign bus.o_contador_ciclos       = contador;
    assign bus.o_estado                = state;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed test-plan scenarios plus a
// randomized run, all compared every cycle against a behavioural model.
module tb_pipeline_sequencer;
    localparam int CW  = 5;
    localparam int DRN = 4;
    localparam int EW  = 7 + 3 + CW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_sequencer_if #(.CANT_BITS_CONTADOR(CW)) bus ();

    pipeline_sequencer #(
        .CANT_CICLOS_DRENADO(DRN),
        .CANT_BITS_CONTADOR (CW)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: o_estado value, cycle count, drain cycles left, last sampled step.
    int m_state = 0;
    int m_cnt   = 0;
    int m_left  = 0;
    bit m_prev  = 1'b1;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] dut_outs();
        return {bus.o_enable_pc, bus.o_enable_if_id, bus.o_enable_pipeline,
                bus.o_burbuja_id_ex, bus.o_flush_if_id, bus.o_disable_for_exception,
                bus.o_fin_programa};
    endfunction

    // ---------------- model + compare (negedge, inputs stable) ----------------
    bit act, drn, exc, bub, br, hlt, halt_ok;
    logic [6:0] eo;
    logic [EW-1:0] e;

    always @(negedge clk) begin
        act = (m_state == 1) || (m_state == 3);
        drn = (m_state == 4);
        exc = bus.i_exception;
        bub = bus.i_bit_burbuja;
        br  = bus.i_branch_taken;
        hlt = bus.i_halt_detected;
        halt_ok = act && hlt && !exc && !bub && !br;
        eo[6] = act && (exc || (!bub && (br || !hlt)));
        eo[5] = eo[6];
        eo[4] = act || drn;
        eo[3] = (act && (exc || bub)) || drn;
        eo[2] = act && (exc || (!bub && br));
        eo[1] = act && exc;
        eo[0] = (m_state == 5);

        if (chk_en) begin
            exp_q.push_back({eo, 3'(m_state), CW'(m_cnt)});
            e = exp_q.pop_front();
            check("outputs", 32'(dut_outs()), 32'(e[EW-1 -: 7]));
            check("estado", 32'(bus.o_estado), 32'(e[CW+2:CW]));
            check("contador", 32'(bus.o_contador_ciclos), 32'(e[CW-1:0]));
        end

        if (!rst_n) begin
            m_state = 0; m_cnt = 0; m_left = 0; m_prev = 1'b1;
        end else begin
            if (eo[4] && m_cnt < (1 << CW) - 1) m_cnt++;
            case (m_state)
                0, 5: if (bus.i_start) begin
                    m_state = bus.i_modo_ejecucion ? 2 : 1;
                    m_cnt   = 0;
                end
                1: if (halt_ok) begin m_state = 4; m_left = DRN; end
                2: if (bus.i_step && !m_prev) m_state = 3;
                3: if (halt_ok) begin m_state = 4; m_left = DRN; end else m_state = 2;
                4: begin m_left--; if (m_left == 0) m_state = 5; end
                default: m_state = 0;
            endcase
            m_prev = bus.i_step;
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input bit rst, input bit st, input bit md, input bit stp,
                         input bit bb, input bit bt, input bit ht, input bit ex);
        @(posedge clk);
        #1;
        rst_n                = rst;
        bus.i_start          = st;
        bus.i_modo_ejecucion = md;
        bus.i_step           = stp;
        bus.i_bit_burbuja    = bb;
        bus.i_branch_taken   = bt;
        bus.i_halt_detected  = ht;
        bus.i_exception      = ex;
    endtask

    task automatic idle();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    logic step_seq [12];
    int exec_n;
    bit r_br;

    initial begin
        rst_n = 1'b0;
        bus.i_start = 0; bus.i_modo_ejecucion = 0; bus.i_step = 0;
        bus.i_bit_burbuja = 0; bus.i_branch_taken = 0;
        bus.i_halt_detected = 0; bus.i_exception = 0;

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_estado", 32'(bus.o_estado), 0);
        check("reset_outs", 32'(dut_outs()), 0);
        check("reset_cnt", 32'(bus.o_contador_ciclos), 0);

        // Start continuous, 10 plain RUN cycles.
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        repeat (11) idle();
        @(negedge clk);
        check("run_estado", 32'(bus.o_estado), 1);
        check("run_outs", 32'(dut_outs()), 32'(7'b1110000));
        check("run_cnt10", 32'(bus.o_contador_ciclos), 10);

        drive(1, 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        check("bubble_outs", 32'(dut_outs()), 32'(7'b0011000));
        drive(1, 0, 0, 0, 1, 1, 0, 0);
        @(negedge clk);
        check("bubble_branch_outs", 32'(dut_outs()), 32'(7'b0011000));
        drive(1, 0, 0, 0, 1, 0, 0, 1);
        @(negedge clk);
        check("exc_bubble_outs", 32'(dut_outs()), 32'(7'b1111110));

        // HALT at cycle N: drain N+1..N+4, DONE at N+5 with counter 19.
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        check("halt_outs", 32'(dut_outs()), 32'(7'b0010000));
        for (int i = 0; i < DRN; i++) begin
            idle();
            @(negedge clk);
            check("drain_estado", 32'(bus.o_estado), 4);
            check("drain_outs", 32'(dut_outs()), 32'(7'b0011000));
        end
        idle();
        @(negedge clk);
        check("done_estado", 32'(bus.o_estado), 5);
        check("done_outs", 32'(dut_outs()), 32'(7'b0000001));
        check("done_cnt", 32'(bus.o_contador_ciclos), 19);
        idle();
        @(negedge clk);
        check("done_cnt_frozen", 32'(bus.o_contador_ciclos), 19);

        drive(1, 1, 0, 0, 0, 0, 0, 0);
        idle();
        @(negedge clk);
        check("restart_estado", 32'(bus.o_estado), 1);
        check("restart_cnt", 32'(bus.o_contador_ciclos), 0);

        // Reset in the middle of a drain.
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        idle();
        idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        @(negedge clk);
        check("drain_reset_estado", 32'(bus.o_estado), 0);
        check("drain_reset_outs", 32'(dut_outs()), 0);
        check("drain_reset_cnt", 32'(bus.o_contador_ciclos), 0);

        // HALT together with a bubble is not accepted.
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 1, 0);
        idle();
        @(negedge clk);
        check("halt_bubble_estado", 32'(bus.o_estado), 1);

        // Counter saturates.
        repeat (40) idle();
        @(negedge clk);
        check("cnt_saturated", 32'(bus.o_contador_ciclos), 31);

        // Step held high through reset must not be taken.
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 0, 0, 0, 0);
        repeat (4) drive(1, 0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        check("step_through_reset", 32'(bus.o_estado), 2);

        // Step mode: hold high 5 cycles, then toggle twice -> 3 executions.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0, 0, 0);
        step_seq = '{1, 1, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0};
        exec_n = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 0, step_seq[i], 0, 0, 0, 0);
            @(negedge clk);
            if (bus.o_estado == 3'd3) exec_n++;
        end
        check("step_exec_count", 32'(exec_n), 3);
        check("step_cnt", 32'(bus.o_contador_ciclos), 3);
        check("step_estado", 32'(bus.o_estado), 2);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            r_br = ($urandom_range(0, 5) == 0);
            drive($urandom_range(0, 199) != 0,
                  $urandom_range(0, 19) == 0,
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 4) == 0,
                  r_br,
                  !r_br && ($urandom_range(0, 9) == 0),
                  $urandom_range(0, 14) == 0);
        end
        idle();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
